smc_input_loader: RTL and testbench
===================================

Name: smc_input_loader

Overview:
Upstream stage of the Supper MOSFET Calculator (SMC).
- Accepts one transistor's (W, V_GS, V_DS) triple per beat over a valid/ready handshake.
- Collects six beats plus the mode into output registers.
- Presents the full parallel operand set (mode, W_0..V_DS_5) to the SMC under an out_valid/out_ready handshake.
- Flags frames that contain illegal zero-valued fields.

Parameters:
- NUM_FET, 6, transistors per frame; fixed at 6 to match the SMC port list.
- TIMEOUT_CYC, 15, idle-cycle limit inside a frame; used only when SMC_LOADER_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  loader can accept a beat.
- in_mode  input  2  SMC mode; sampled on beat 0 only.
- in_w  input  3  W of the current transistor.
- in_vgs  input  3  V_GS of the current transistor.
- in_vds  input  3  V_DS of the current transistor.
- out_valid  output  1  full operand set is valid.
- out_ready  input  1  SMC consumer accepts the set.
- mode  output  2  registered mode.
- W_0..W_5  output  3 each  registered W per transistor.
- V_GS_0..V_GS_5  output  3 each  registered V_GS per transistor.
- V_DS_0..V_DS_5  output  3 each  registered V_DS per transistor.
- out_err  output  1  frame contained a zero field; valid with out_valid.
- frame_abort  output  1  one-cycle pulse when a partial frame is discarded.

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous, active-high.
- Reset, sampled on a clk rising edge:
  - state=IDLE, beat counter=0.
  - All 18 field outputs and mode = 0.
  - out_valid=0, out_err=0, frame_abort=0.
  - in_ready=0 while rst is high; in_ready=1 the first cycle after rst is released.
- Beat acceptance: a beat is accepted when in_valid && in_ready at a rising edge.
- States:
  - IDLE: in_ready=1. Beat accepted -> capture mode and fields into slot 0, cnt=1, go to LOAD.
  - LOAD: in_ready=1. Beat accepted -> write slot cnt, cnt++. Acceptance of beat 5 (cnt==5) -> HOLD.
  - HOLD: in_ready=0, out_valid=1. out_valid && out_ready -> IDLE, out_valid=0 the next cycle.
- Slot k (W_k, V_GS_k, V_DS_k) updates in the cycle beat k is accepted. Other slots are untouched.
- in_mode is ignored on beats 1..5.
- Latency: out_valid rises the cycle after beat 5 is accepted. Minimum frame period is 7 cycles (6 beats + 1 handshake).
- While out_valid=1, all field outputs, mode and out_err are stable until the handshake completes.
- After the handshake, fields keep their last values until overwritten by the next frame.
- out_err:
  - Cleared on beat 0 acceptance.
  - Set if any accepted beat of the frame has in_w==0, in_vgs==0 or in_vds==0 (legal SMC range is 1..7).
  - Sticky until the next beat 0. Does not block the frame.
- No beat can be accepted in the same cycle as the output handshake, because in_ready=0 in HOLD.
- out_ready is ignored outside HOLD.
- in_valid low during LOAD holds state: no bubble penalty, cnt unchanged.
- Reset mid-frame (LOAD or HOLD): the partial frame is dropped without a frame_abort pulse, and all outputs return to reset values.

Optional Feature:
Macro: SMC_LOADER_TIMEOUT_EN.
- Defined:
  - In LOAD, an idle counter increments each cycle with in_valid=0 and clears on each accepted beat.
  - When it reaches TIMEOUT_CYC: go to IDLE, cnt=0, frame_abort=1 for one cycle.
  - Fields already written stay as-is; out_valid is not asserted.
  - The counter is inactive in IDLE and HOLD.
- Undefined: LOAD waits indefinitely, frame_abort is tied 0, and no idle counter is instantiated.

Test Plan:
- Basic frame: mode=2, beats (1,2,3),(4,5,6),(7,1,2),(3,4,5),(6,7,1),(2,3,4) back-to-back, out_ready=1 -> out_valid high exactly one cycle, the cycle after beat 5; W_0=1, V_DS_5=4, mode=2; out_err=0; in_ready returns 1 the following cycle.
- Backpressure: same frame with out_ready=0 for 4 cycles, then 1 -> out_valid held 5 cycles, outputs stable throughout; in_valid asserted during HOLD is not accepted (in_ready=0).
- Gapped input: 2 idle cycles inserted between each beat, macro undefined -> same outputs as the basic frame; out_valid 1 cycle after the last beat; in_mode changed to 3 on beat 2 -> mode remains 2.
- Zero field: beat 3 = (0,4,5) -> out_err=1 with out_valid; next frame with all-legal fields -> out_err=0.
- Reset mid-frame: rst high for 1 cycle after beat 3 -> all outputs 0, state IDLE; a new full frame completes normally with correct values.
- Timeout (SMC_LOADER_TIMEOUT_EN, TIMEOUT_CYC=15): 2 beats, then in_valid=0 for 15 cycles -> frame_abort pulses once, no out_valid; the next 6 beats produce a correct frame starting at slot 0.

Source files
------------

// File: rtl/smc_input_loader_if.sv
// Beat-in / operand-out bundle between the SMC loader and its neighbours.
// master: upstream producer plus SMC consumer side; slave: the loader itself.
interface smc_input_loader_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_mode;
  logic [2:0] in_w;
  logic [2:0] in_vgs;
  logic [2:0] in_vds;

  logic       out_valid;
  logic       out_ready;
  logic [1:0] mode;
  logic [2:0] W_0, W_1, W_2, W_3, W_4, W_5;
  logic [2:0] V_GS_0, V_GS_1, V_GS_2, V_GS_3, V_GS_4, V_GS_5;
  logic [2:0] V_DS_0, V_DS_1, V_DS_2, V_DS_3, V_DS_4, V_DS_5;
  logic       out_err;
  logic       frame_abort;

  modport master (
    output in_valid, in_mode, in_w, in_vgs, in_vds, out_ready,
    input  in_ready, out_valid, mode,
    input  W_0, W_1, W_2, W_3, W_4, W_5,
    input  V_GS_0, V_GS_1, V_GS_2, V_GS_3, V_GS_4, V_GS_5,
    input  V_DS_0, V_DS_1, V_DS_2, V_DS_3, V_DS_4, V_DS_5,
    input  out_err, frame_abort
  );

  modport slave (
    input  in_valid, in_mode, in_w, in_vgs, in_vds, out_ready,
    output in_ready, out_valid, mode,
    output W_0, W_1, W_2, W_3, W_4, W_5,
    output V_GS_0, V_GS_1, V_GS_2, V_GS_3, V_GS_4, V_GS_5,
    output V_DS_0, V_DS_1, V_DS_2, V_DS_3, V_DS_4, V_DS_5,
    output out_err, frame_abort
  );
endinterface

// File: rtl/smc_input_loader.sv
// Collects six (W, V_GS, V_DS) beats plus mode into a parallel SMC operand set.
// Latency: out_valid the cycle after beat 5 is accepted; 7-cycle minimum frame period.
// Backpressure: in_ready drops while the set is held for out_ready; SMC_LOADER_TIMEOUT_EN adds an in-frame idle abort.
module smc_input_loader #(
  parameter int NUM_FET = 6
`ifdef SMC_LOADER_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 15
`endif
) (
  input  logic              clk,
  input  logic              rst,
  smc_input_loader_if.slave bus
);

  typedef struct packed {
    logic [2:0] w;
    logic [2:0] vgs;
    logic [2:0] vds;
  } fet_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [2:0] LAST_BEAT = 3'(NUM_FET - 1);

  state_t                   state, state_nxt;
  logic [2:0]               cnt, cnt_nxt;
  fet_t [NUM_FET-1:0]       slot;
  logic [1:0]               mode_q;
  logic                     err_q;
  logic                     acc;
  logic                     beat_zero;
  fet_t                     beat;

  // rst gates in_ready combinationally so no beat is offered during reset
  assign bus.in_ready = !rst && (state != HOLD);
  assign bus.out_valid = (state == HOLD);
  assign acc = bus.in_valid && bus.in_ready;

  assign beat      = '{w: bus.in_w, vgs: bus.in_vgs, vds: bus.in_vds};
  assign beat_zero = (bus.in_w == 3'd0) || (bus.in_vgs == 3'd0) || (bus.in_vds == 3'd0);

`ifdef SMC_LOADER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  logic [IDLE_W-1:0] idle_cnt;
  logic              timeout;
  logic              abort_q;

  always_ff @(posedge clk) begin
    if (rst || state != LOAD || acc) begin
      idle_cnt <= '0;
    end else if (!bus.in_valid) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      abort_q <= 1'b0;
    end else begin
      abort_q <= timeout;
    end
  end

  assign bus.frame_abort = abort_q;
`else
  assign bus.frame_abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
`ifdef SMC_LOADER_TIMEOUT_EN
    timeout   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (acc) begin
          cnt_nxt   = 3'd1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (acc) begin
          if (cnt == LAST_BEAT) begin
            cnt_nxt   = 3'd0;
            state_nxt = HOLD;
          end else begin
            cnt_nxt = cnt + 3'd1;
          end
        end
`ifdef SMC_LOADER_TIMEOUT_EN
        // this is the TIMEOUT_CYC-th consecutive idle cycle of the frame
        else if (!bus.in_valid && idle_cnt == IDLE_W'(TIMEOUT_CYC - 1)) begin
          timeout   = 1'b1;
          cnt_nxt   = 3'd0;
          state_nxt = IDLE;
        end
`endif
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  // cnt is always 0 in IDLE, so it addresses slot 0 for the first beat too
  always_ff @(posedge clk) begin
    if (rst) begin
      slot   <= '0;
      mode_q <= 2'd0;
      err_q  <= 1'b0;
    end else if (acc) begin
      slot[cnt] <= beat;
      if (state == IDLE) begin
        mode_q <= bus.in_mode;
        err_q  <= beat_zero;
      end else begin
        err_q  <= err_q | beat_zero;
      end
    end
  end

  assign bus.mode    = mode_q;
  assign bus.out_err = err_q;

  assign bus.W_0 = slot[0].w;
  assign bus.W_1 = slot[1].w;
  assign bus.W_2 = slot[2].w;
  assign bus.W_3 = slot[3].w;
  assign bus.W_4 = slot[4].w;
  assign bus.W_5 = slot[5].w;

  assign bus.V_GS_0 = slot[0].vgs;
  assign bus.V_GS_1 = slot[1].vgs;
  assign bus.V_GS_2 = slot[2].vgs;
  assign bus.V_GS_3 = slot[3].vgs;
  assign bus.V_GS_4 = slot[4].vgs;
  assign bus.V_GS_5 = slot[5].vgs;

  assign bus.V_DS_0 = slot[0].vds;
  assign bus.V_DS_1 = slot[1].vds;
  assign bus.V_DS_2 = slot[2].vds;
  assign bus.V_DS_3 = slot[3].vds;
  assign bus.V_DS_4 = slot[4].vds;
  assign bus.V_DS_5 = slot[5].vds;

endmodule

// File: tb/tb_smc_input_loader.sv
// Scoreboard bench for smc_input_loader: frames are predicted as beats are driven
// and compared when the operand set is handed over.
module tb_smc_input_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  smc_input_loader_if bus();

  smc_input_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [1:0]      mode;
    logic [5:0][8:0] f;
    logic            err;
  } frame_t;

  frame_t     sb[$];
  int         vec = 0;
  int         mis = 0;
  int         abort_cnt = 0;
  int         ovld_cycles = 0;
  logic [8:0] bt [6];
  logic [1:0] md [6];

  always @(negedge clk) begin
    if (bus.frame_abort === 1'b1) abort_cnt++;
    if (bus.out_valid === 1'b1) ovld_cycles++;
  end

  function automatic frame_t snap();
    frame_t s;
    s.mode = bus.mode;
    s.err  = bus.out_err;
    s.f[0] = {bus.W_0, bus.V_GS_0, bus.V_DS_0};
    s.f[1] = {bus.W_1, bus.V_GS_1, bus.V_DS_1};
    s.f[2] = {bus.W_2, bus.V_GS_2, bus.V_DS_2};
    s.f[3] = {bus.W_3, bus.V_GS_3, bus.V_DS_3};
    s.f[4] = {bus.W_4, bus.V_GS_4, bus.V_DS_4};
    s.f[5] = {bus.W_5, bus.V_GS_5, bus.V_DS_5};
    return s;
  endfunction

  // Drives nbeats beats from bt/md with gap idle cycles between them; returns on the
  // negedge of the cycle after the last acceptance. Full frames are predicted into sb.
  task automatic send_frame(input int nbeats, input int gap);
    frame_t e;
    int     n;
    e      = '0;
    e.mode = md[0];
    for (int k = 0; k < nbeats; k++) begin
      if (k > 0) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          bus.in_valid = 1'b0;
        end
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_mode  = md[k];
      {bus.in_w, bus.in_vgs, bus.in_vds} = bt[k];
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      vec++;
      if (n >= 50) begin
        mis++;
        $display("FAIL beat_accept beat=%0d in_ready=%b required=1", k, bus.in_ready);
      end
      e.f[k] = bt[k];
      if (bt[k][8:6] == 3'd0 || bt[k][5:3] == 3'd0 || bt[k][2:0] == 3'd0) e.err = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (nbeats == 6) sb.push_back(e);
  endtask

  task automatic load_basic();
    bt = '{9'o123, 9'o456, 9'o712, 9'o345, 9'o671, 9'o234};
    md = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_mode = 2'd0; bus.out_ready = 1'b0;
    bus.in_w = 3'd0; bus.in_vgs = 3'd0; bus.in_vds = 3'd0;
    repeat (2) @(negedge clk);
    vec++; if (bus.in_ready !== 1'b0) begin mis++; $display("FAIL rst_in_ready got=%b required=0", bus.in_ready); end
    vec++; if (snap() !== '0) begin mis++; $display("FAIL rst_fields got=%h required=0", snap()); end
    vec++; if ({bus.out_valid, bus.frame_abort} !== 2'b00) begin
      mis++; $display("FAIL rst_flags got=%b required=00", {bus.out_valid, bus.frame_abort});
    end
    rst = 1'b0;
    @(negedge clk);
    vec++; if (bus.in_ready !== 1'b1) begin mis++; $display("FAIL rst_release_in_ready got=%b required=1", bus.in_ready); end
  endtask

  task automatic test_basic();
    frame_t exp, got;
    int     c0;
    load_basic();
    bus.out_ready = 1'b1;
    c0 = ovld_cycles;
    send_frame(6, 0);
    vec++; if (bus.out_valid !== 1'b1) begin mis++; $display("FAIL basic_latency out_valid=%b required=1", bus.out_valid); end
    exp = sb.pop_front(); got = snap();
    vec++; if (got !== exp) begin mis++; $display("FAIL basic_frame got=%h required=%h", got, exp); end
    vec++; if ({bus.W_0, bus.V_DS_5, bus.mode} !== {3'd1, 3'd4, 2'd2}) begin
      mis++; $display("FAIL basic_w0_vds5_mode got=%h required=%h", {bus.W_0, bus.V_DS_5, bus.mode}, {3'd1, 3'd4, 2'd2});
    end
    @(negedge clk);
    vec++; if (bus.out_valid !== 1'b0) begin mis++; $display("FAIL basic_one_cycle out_valid=%b required=0", bus.out_valid); end
    vec++; if (bus.in_ready !== 1'b1) begin mis++; $display("FAIL basic_in_ready_back got=%b required=1", bus.in_ready); end
    vec++; if (ovld_cycles - c0 !== 1) begin mis++; $display("FAIL basic_valid_cycles got=%0d required=1", ovld_cycles - c0); end
  endtask

  task automatic test_backpressure();
    frame_t exp, held;
    int     c0;
    load_basic();
    bt[0] = 9'o765;
    bus.out_ready = 1'b0;
    c0 = ovld_cycles;
    send_frame(6, 0);
    held = snap();
    bus.in_valid = 1'b1;
    {bus.in_w, bus.in_vgs, bus.in_vds} = 9'o777;
    vec++; if (bus.in_ready !== 1'b0) begin mis++; $display("FAIL bp_hold_in_ready got=%b required=0", bus.in_ready); end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      vec++; if (bus.out_valid !== 1'b1 || snap() !== held) begin
        mis++; $display("FAIL bp_stable cyc=%0d valid=%b got=%h required=%h", i, bus.out_valid, snap(), held);
      end
      if (i == 4) bus.out_ready = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    vec++; if (bus.out_valid !== 1'b0) begin mis++; $display("FAIL bp_release out_valid=%b required=0", bus.out_valid); end
    vec++; if (ovld_cycles - c0 !== 5) begin mis++; $display("FAIL bp_valid_cycles got=%0d required=5", ovld_cycles - c0); end
    exp = sb.pop_front();
    vec++; if (held !== exp) begin mis++; $display("FAIL bp_frame got=%h required=%h", held, exp); end
    vec++; if (snap() !== exp) begin mis++; $display("FAIL bp_fields_kept got=%h required=%h", snap(), exp); end
  endtask

  task automatic test_gapped();
    frame_t exp, got;
    load_basic();
    md[2] = 2'd3;
    bus.out_ready = 1'b1;
    send_frame(6, 2);
    vec++; if (bus.out_valid !== 1'b1) begin mis++; $display("FAIL gap_latency out_valid=%b required=1", bus.out_valid); end
    exp = sb.pop_front(); got = snap();
    vec++; if (got !== exp) begin mis++; $display("FAIL gap_frame got=%h required=%h", got, exp); end
    @(negedge clk);
  endtask

  task automatic test_zero_field();
    frame_t exp, got;
    load_basic();
    bt[3] = 9'o045;
    md = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    bus.out_ready = 1'b1;
    send_frame(6, 0);
    vec++; if (bus.out_err !== 1'b1) begin mis++; $display("FAIL zero_err got=%b required=1", bus.out_err); end
    exp = sb.pop_front(); got = snap();
    vec++; if (got !== exp) begin mis++; $display("FAIL zero_frame got=%h required=%h", got, exp); end
    load_basic();
    send_frame(6, 0);
    vec++; if (bus.out_err !== 1'b0) begin mis++; $display("FAIL zero_err_clear got=%b required=0", bus.out_err); end
    exp = sb.pop_front(); got = snap();
    vec++; if (got !== exp) begin mis++; $display("FAIL zero_next_frame got=%h required=%h", got, exp); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    frame_t exp, got;
    int     a0;
    load_basic();
    a0 = abort_cnt;
    send_frame(4, 0);
    rst = 1'b1;
    #1;
    vec++; if (bus.in_ready !== 1'b0) begin mis++; $display("FAIL mid_rst_in_ready got=%b required=0", bus.in_ready); end
    @(negedge clk);
    vec++; if (snap() !== '0 || bus.out_valid !== 1'b0) begin
      mis++; $display("FAIL mid_rst_outputs got=%h valid=%b required=0", snap(), bus.out_valid);
    end
    rst = 1'b0;
    @(negedge clk);
    vec++; if (bus.in_ready !== 1'b1) begin mis++; $display("FAIL mid_rst_idle in_ready=%b required=1", bus.in_ready); end
    bt = '{9'o777, 9'o111, 9'o246, 9'o135, 9'o764, 9'o521};
    md = '{2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    send_frame(6, 0);
    exp = sb.pop_front(); got = snap();
    vec++; if (got !== exp) begin mis++; $display("FAIL mid_rst_new_frame got=%h required=%h", got, exp); end
    vec++; if (abort_cnt - a0 !== 0) begin mis++; $display("FAIL mid_rst_no_abort got=%0d required=0", abort_cnt - a0); end
    @(negedge clk);
  endtask

`ifdef SMC_LOADER_TIMEOUT_EN
  task automatic test_timeout();
    frame_t exp, got;
    int     a0, o0;
    load_basic();
    a0 = abort_cnt; o0 = ovld_cycles;
    send_frame(2, 0);
    repeat (14) @(negedge clk);
    vec++; if (bus.frame_abort !== 1'b0) begin mis++; $display("FAIL to_early frame_abort=%b required=0", bus.frame_abort); end
    @(negedge clk);
    vec++; if (bus.frame_abort !== 1'b1) begin mis++; $display("FAIL to_pulse frame_abort=%b required=1", bus.frame_abort); end
    repeat (4) @(negedge clk);
    vec++; if (abort_cnt - a0 !== 1) begin mis++; $display("FAIL to_pulse_count got=%0d required=1", abort_cnt - a0); end
    vec++; if (ovld_cycles - o0 !== 0) begin mis++; $display("FAIL to_no_valid got=%0d required=0", ovld_cycles - o0); end
    bt = '{9'o321, 9'o654, 9'o217, 9'o543, 9'o176, 9'o432};
    md = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
    send_frame(6, 0);
    exp = sb.pop_front(); got = snap();
    vec++; if (got !== exp) begin mis++; $display("FAIL to_next_frame got=%h required=%h", got, exp); end
    @(negedge clk);
  endtask
`else
  task automatic test_long_stall();
    frame_t exp, got;
    int     a0;
    load_basic();
    a0 = abort_cnt;
    send_frame(6, 20);
    vec++; if (abort_cnt - a0 !== 0) begin mis++; $display("FAIL stall_no_abort got=%0d required=0", abort_cnt - a0); end
    exp = sb.pop_front(); got = snap();
    vec++; if (got !== exp) begin mis++; $display("FAIL stall_frame got=%h required=%h", got, exp); end
    @(negedge clk);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_basic();
    test_gapped();
    test_zero_field();
    test_reset_mid_frame();
`ifdef SMC_LOADER_TIMEOUT_EN
    test_timeout();
`else
    test_long_stall();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
